// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-port synchronous SRAM (1-cycle read
// latency) between instruction fetch and load/store. One grant per cycle, MEM
// preferred unless IF has been passed over STARVE_MAX times. The port granted
// last cycle is masked because its request still shows the access completing.
// Responses come back the following cycle as a one-cycle valid pulse. A flush
// cancels both new grants and the response currently in flight.
module sram_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              mem_req,
    input  logic [3:0]        mem_wen,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_valid,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              if_stall,
    output logic              mem_stall,
    output logic              sram_en,
    output logic [3:0]        sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_MEM  = 2'd2
    } owner_t;

    owner_t            r_owner;
    owner_t            w_owner_nxt;
    logic [SW-1:0]     r_starve;
    logic [SW-1:0]     w_starve_nxt;
    logic              r_mem_rd;
    logic              w_mem_rd_nxt;
    logic [DATA_W-1:0] r_if_hold;
    logic [DATA_W-1:0] r_mem_hold;

    logic w_elig_if;
    logic w_elig_mem;
    logic w_gnt_if;
    logic w_gnt_mem;
    logic w_if_valid;
    logic w_mem_valid;
    logic w_mem_load;

    // Arbitration, SRAM port drive and next-state for owner / starvation count.
    always_comb begin
        w_elig_if    = if_req  & (r_owner != OWN_IF);
        w_elig_mem   = mem_req & (r_owner != OWN_MEM);
        w_gnt_if     = 1'b0;
        w_gnt_mem    = 1'b0;
        w_owner_nxt  = OWN_NONE;
        w_starve_nxt = r_starve;
        w_mem_rd_nxt = r_mem_rd;

        // No grants at all while held in reset or during a flush.
        if (!reset && !flush) begin
            if (w_elig_mem && !(w_elig_if && (r_starve == STARVE_LIM))) begin
                w_gnt_mem = 1'b1;
            end else if (w_elig_if) begin
                w_gnt_if = 1'b1;
            end
        end

        if (w_gnt_mem) begin
            w_owner_nxt  = OWN_MEM;
            w_mem_rd_nxt = (mem_wen == 4'b0000);
        end else if (w_gnt_if) begin
            w_owner_nxt = OWN_IF;
        end

        // Count MEM wins that passed over a waiting fetch; saturate at the limit.
        if (w_gnt_if || !if_req) begin
            w_starve_nxt = '0;
        end else if (w_gnt_mem && w_elig_if && (r_starve != STARVE_LIM)) begin
            w_starve_nxt = r_starve + SW'(1);
        end

        sram_en    = w_gnt_if | w_gnt_mem;
        sram_wen   = w_gnt_mem ? mem_wen : 4'b0000;
        sram_addr  = w_gnt_mem ? mem_addr : if_addr;
        sram_wdata = w_gnt_mem ? mem_wdata : '0;
    end

    // Response side: valid the cycle after a grant unless flushed; rdata
    // shows the SRAM word on a valid read, otherwise the last captured word.
    always_comb begin
        w_if_valid  = (r_owner == OWN_IF)  & ~flush;
        w_mem_valid = (r_owner == OWN_MEM) & ~flush;
        w_mem_load  = w_mem_valid & r_mem_rd;

        if_valid  = w_if_valid;
        mem_valid = w_mem_valid;
        if_rdata  = w_if_valid ? sram_rdata : r_if_hold;
        mem_rdata = w_mem_load ? sram_rdata : r_mem_hold;
        if_stall  = if_req  & ~w_if_valid;
        mem_stall = mem_req & ~w_mem_valid;
    end

    // Owner / starvation / read-flag state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner  <= OWN_NONE;
            r_starve <= '0;
            r_mem_rd <= 1'b0;
        end else begin
            r_owner  <= w_owner_nxt;
            r_starve <= w_starve_nxt;
            r_mem_rd <= w_mem_rd_nxt;
        end
    end

    // Capture returned words so rdata holds between responses; stores leave
    // the MEM hold untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_if_hold  <= '0;
            r_mem_hold <= '0;
        end else begin
            if (w_if_valid) begin
                r_if_hold <= sram_rdata;
            end
            if (w_mem_load) begin
                r_mem_hold <= sram_rdata;
            end
        end
    end

endmodule
